// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Receives a program image over an 8N1 UART line and writes it, one 32-bit
//   word at a time, into instruction memory. The pipeline is held in reset
//   until the whole image has been written.
//
//   Frame format: 0xA5, N (word count), 4*N payload bytes (little-endian words),
//   and, when LOADER_CHECKSUM_EN is defined, one trailing byte equal to the XOR
//   of all payload bytes.
//
//   Configuration macro: LOADER_CHECKSUM_EN (adds the CHK state and XOR check).
//
//   Parameters
//     CLKS_PER_BIT  clk_div cycles per UART bit
//     ADDR_W        instruction-memory word-address width
//   Ports
//     clk_div     in   sole clock, rising edge
//     rst         in   asynchronous active-low reset
//     uart_rx     in   serial line, idle high, LSB first
//     imem_we     out  one-cycle instruction-memory write strobe
//     imem_addr   out  word address of the current write (wraps)
//     imem_wdata  out  instruction word being written
//     core_rst_n  out  active-low pipeline reset, high only once loaded
//     load_done   out  high once the program is loaded and the core released
//     frame_err   out  sticky: a stop bit was sampled low
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8
) (
  input  logic              clk_div,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              frame_err
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  // Reset: asserts asynchronously, releases two clk_div edges later.
  logic [1:0] rstSync;
  logic       rstN;

  always_ff @(posedge clk_div or negedge rst) begin
    if (!rst) rstSync <= 2'b00;
    else      rstSync <= {rstSync[0], 1'b1};
  end
  assign rstN = rstSync[1];

  // Serial input: two synchronizer flops plus one history flop for edge detect.
  // NOTE: these reset to 1 (line idle) so reset release never looks like a start bit.
  logic [2:0] rxPipe;
  logic       rxS;
  logic       rxPrev;

  always_ff @(posedge clk_div or negedge rstN) begin
    if (!rstN) rxPipe <= 3'b111;
    else       rxPipe <= {rxPipe[1:0], uart_rx};
  end
  assign rxS    = rxPipe[1];
  assign rxPrev = rxPipe[2];

  // ---------------------------------------------------------------- receiver
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
  rxState_t         rxState, rxNext;
  logic [CNT_W-1:0] rxCnt;
  logic [2:0]       bitIdx;
  logic [7:0]       rxByte;
  logic             byteValid;
  logic             stopErr;
  logic             halfTick;
  logic             bitTick;

  assign halfTick = (rxCnt == CNT_W'(HALF - 1));
  assign bitTick  = (rxCnt == CNT_W'(CLKS_PER_BIT - 1));

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    rxNext = rxState;
    unique case (rxState)
      RX_IDLE:  if (rxPrev && !rxS) rxNext = RX_START;
      // Line back high at mid-start means a glitch: drop it silently.
      RX_START: if (halfTick) rxNext = rxS ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bitTick && bitIdx == 3'd7) rxNext = RX_STOP;
      RX_STOP:  if (bitTick) rxNext = RX_IDLE;
      default:  rxNext = RX_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk_div or negedge rstN) begin
    if (!rstN) begin
      rxState   <= RX_IDLE;
      rxCnt     <= '0;
      bitIdx    <= '0;
      rxByte    <= '0;
      byteValid <= 1'b0;
      stopErr   <= 1'b0;
    end else begin
      rxState   <= rxNext;
      byteValid <= 1'b0;
      stopErr   <= 1'b0;
      // Counter restarts on every state change and every bit boundary, so the
      // start check lands mid-bit and later samples stay one bit apart.
      if (rxState == RX_IDLE || rxState != rxNext || bitTick) rxCnt <= '0;
      else                                                     rxCnt <= rxCnt + 1'b1;
      if (rxState == RX_START) bitIdx <= '0;
      if (rxState == RX_DATA && bitTick) begin
        rxByte <= {rxS, rxByte[7:1]};
        bitIdx <= bitIdx + 1'b1;
      end
      if (rxState == RX_STOP && bitTick) begin
        byteValid <= rxS;
        stopErr   <= !rxS;
      end
    end
  end

  // ------------------------------------------------------------------ loader
  typedef enum logic [2:0] {
    IDLE, LEN, DATA,
`ifdef LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } ldState_t;

  ldState_t    ldState, ldNext;
  logic [7:0]  wordCount;
  logic [7:0]  wordIdx;
  logic [1:0]  byteIdx;
  logic [23:0] wordBuf;
  logic        lastWrite;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  chkAcc;
`endif

  // wordCount is never 0 while in DATA (N=0 goes straight to DONE).
  assign lastWrite = imem_we && (wordIdx == wordCount - 8'd1);

  // A framing error while a frame is in progress restarts from IDLE so the
  // host can simply resend; ERR is only reached on a checksum mismatch.
  always_comb begin
    ldNext = ldState;
    unique case (ldState)
      IDLE: if (byteValid && rxByte == 8'hA5) ldNext = LEN;
      LEN: begin
        if (stopErr)        ldNext = IDLE;
        else if (byteValid) ldNext = (rxByte == 8'd0) ? DONE : DATA;
      end
      DATA: begin
        if (stopErr) ldNext = IDLE;
`ifdef LOADER_CHECKSUM_EN
        else if (lastWrite) ldNext = CHK;
`else
        else if (lastWrite) ldNext = DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CHK: begin
        if (stopErr)        ldNext = IDLE;
        else if (byteValid) ldNext = (rxByte == chkAcc) ? DONE : ERR;
      end
`endif
      DONE:    ldNext = DONE;
      ERR:     ldNext = ERR;
      default: ldNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_div or negedge rstN) begin
    if (!rstN) begin
      ldState    <= IDLE;
      wordCount  <= '0;
      wordIdx    <= '0;
      byteIdx    <= '0;
      wordBuf    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      load_done  <= 1'b0;
      frame_err  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chkAcc     <= '0;
`endif
    end else begin
      ldState    <= ldNext;
      // Strobe lands the cycle after the 4th byte of a word.
      imem_we    <= (ldState == DATA) && byteValid && (byteIdx == 2'd3);
      core_rst_n <= (ldNext == DONE);
      load_done  <= (ldNext == DONE);
      if (stopErr) frame_err <= 1'b1;

      if (ldState == LEN && byteValid) begin
        wordCount <= rxByte;
        wordIdx   <= '0;
        byteIdx   <= '0;
        imem_addr <= '0;
`ifdef LOADER_CHECKSUM_EN
        chkAcc    <= '0;
`endif
      end

      if (ldState == DATA && byteValid) begin
        byteIdx <= byteIdx + 1'b1;
        // Little-endian: first byte ends up in bits [7:0].
        wordBuf <= {rxByte, wordBuf[23:8]};
        if (byteIdx == 2'd3) imem_wdata <= {rxByte, wordBuf};
`ifdef LOADER_CHECKSUM_EN
        chkAcc  <= chkAcc ^ rxByte;
`endif
      end

      if (imem_we) begin
        imem_addr <= imem_addr + ADDR_W'(1);
        wordIdx   <= wordIdx + 8'd1;
      end
    end
  end

endmodule
